mem_access_unit: RTL and testbench

//  Data-memory side of the control decode: consumes MemRead/MemWrite/MemFunc plus LL/SC flags.

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Request/acknowledge data-memory bus between the access unit (master) and memory (slave).
// Addresses are word addresses; byte lanes are big-endian (MemBE[3] = bits 31:24).
interface mem_access_unit_if;
    logic        MemReq;
    logic        MemWE;
    logic [29:0] MemAddr;
    logic [3:0]  MemBE;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;

    modport master (
        output MemReq, MemWE, MemAddr, MemBE, MemWData,
        input  MemAck, MemRData
    );

    modport slave (
        input  MemReq, MemWE, MemAddr, MemBE, MemWData,
        output MemAck, MemRData
    );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access unit: B/H/W/LWL/LWR/SWL/SWR and LL/SC over a req/ack bus,
// stalling the pipeline until the access completes, times out, or is rejected.
module mem_access_unit #(
    parameter int TIMEOUT = 256
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        MemFunc,
    input  logic              Link,
    input  logic              Cond,
    input  logic              LLClear,
    input  logic [31:0]       Address,
    input  logic [31:0]       RtData,
    output logic [31:0]       ReadData,
    output logic              Stall,
    output logic              Done,
    output logic              AddrErr,
    output logic              BusErr,
    mem_access_unit_if.master bus
);

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_WL = 3'b010;
    localparam logic [2:0] F_W  = 3'b011;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_WR = 3'b110;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               llbit;
    logic [29:0]        lladdr;
    logic [2:0]         op_func;
    logic [1:0]         op_k;
    logic [31:0]        op_rt;
    logic               op_wr;
    logic               op_sc;
    logic               op_ll;

    logic               start;
    logic [2:0]         eff_func;
    logic               is_sc;
    logic               is_ll;
    logic               mis;
    logic               sc_ok;
    logic [35:0]        st_fmt;

    function automatic logic misaligned(input logic [2:0] func, input logic [1:0] k);
        case (func)
            F_H, F_HU:               return k[0];
            F_B, F_BU, F_WL, F_WR:   return 1'b0;
            default:                 return k != 2'b00;
        endcase
    endfunction

    // Selects the addressed lanes of the bus word and extends/merges into a register value.
    function automatic logic [31:0] load_format(input logic [2:0] func, input logic [1:0] k,
                                                input logic [31:0] mem, input logic [31:0] rt);
        logic [31:0]        bsel;
        logic [15:0]        hsel;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] ext_b;
        logic signed [31:0] ext_h;
        logic [4:0]         lsh;
        logic [4:0]         rsh;
        bsel  = mem >> {~k, 3'b000};
        hsel  = k[1] ? mem[15:0] : mem[31:16];
        sb    = bsel[7:0];
        sh    = hsel;
        ext_b = sb;
        ext_h = sh;
        lsh   = {k, 3'b000};
        rsh   = {~k, 3'b000};
        case (func)
            F_B:     return ext_b;
            F_BU:    return {24'd0, bsel[7:0]};
            F_H:     return ext_h;
            F_HU:    return {16'd0, hsel};
            F_WL:    return (mem << lsh) | (rt & ~(32'hFFFF_FFFF << lsh));
            F_WR:    return (mem >> rsh) | (rt & ~(32'hFFFF_FFFF >> rsh));
            default: return mem;
        endcase
    endfunction

    // Returns {byte enables, lane-aligned write data}.
    function automatic logic [35:0] store_format(input logic [2:0] func, input logic [1:0] k,
                                                 input logic [31:0] rt);
        case (func)
            F_B, F_BU: return {4'b1000 >> k, {4{rt[7:0]}}};
            F_H, F_HU: return {4'b1100 >> k, {2{rt[15:0]}}};
            F_WL:      return {4'b1111 >> k, rt >> {k, 3'b000}};
            F_WR:      return {4'b1111 << ~k, rt << {~k, 3'b000}};
            default:   return {4'b1111, rt};
        endcase
    endfunction

    assign start    = MemRead | MemWrite;
    assign is_sc    = MemWrite & Cond;
    assign is_ll    = ~MemWrite & Link;
    assign eff_func = (is_sc | is_ll) ? F_W : MemFunc;
    assign mis      = misaligned(eff_func, Address[1:0]);
    assign sc_ok    = llbit & ~LLClear & (lladdr == Address[31:2]);
    assign st_fmt   = store_format(eff_func, Address[1:0], RtData);
    assign Stall    = (start & (state != S_BUSY)) | (state == S_BUSY);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            llbit        <= 1'b0;
            lladdr       <= '0;
            op_func      <= '0;
            op_k         <= '0;
            op_rt        <= '0;
            op_wr        <= 1'b0;
            op_sc        <= 1'b0;
            op_ll        <= 1'b0;
            ReadData     <= '0;
            Done         <= 1'b0;
            AddrErr      <= 1'b0;
            BusErr       <= 1'b0;
            bus.MemReq   <= 1'b0;
            bus.MemWE    <= 1'b0;
            bus.MemAddr  <= '0;
            bus.MemBE    <= '0;
            bus.MemWData <= '0;
        end else begin
            Done    <= 1'b0;
            AddrErr <= 1'b0;
            BusErr  <= 1'b0;
            case (state)
                S_BUSY: begin
                    if (bus.MemAck) begin
                        state      <= S_DONE;
                        Done       <= 1'b1;
                        bus.MemReq <= 1'b0;
                        if (op_wr) begin
                            ReadData <= {31'd0, op_sc};
                            if (op_sc) llbit <= 1'b0;
                        end else begin
                            ReadData <= load_format(op_func, op_k, bus.MemRData, op_rt);
                            if (op_ll) begin
                                llbit  <= 1'b1;
                                lladdr <= bus.MemAddr;
                            end
                        end
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= S_DONE;
                        Done       <= 1'b1;
                        BusErr     <= 1'b1;
                        ReadData   <= '0;
                        bus.MemReq <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    // A request seen in DONE is handled exactly like one seen in IDLE.
                    state <= S_IDLE;
                    if (start) begin
                        if (mis) begin
                            state    <= S_DONE;
                            Done     <= 1'b1;
                            AddrErr  <= 1'b1;
                            ReadData <= '0;
                        end else if (is_sc && !sc_ok) begin
                            state    <= S_DONE;
                            Done     <= 1'b1;
                            ReadData <= '0;
                            llbit    <= 1'b0;
                        end else begin
                            state        <= S_BUSY;
                            cnt          <= '0;
                            op_func      <= eff_func;
                            op_k         <= Address[1:0];
                            op_rt        <= RtData;
                            op_wr        <= MemWrite;
                            op_sc        <= is_sc;
                            op_ll        <= is_ll;
                            bus.MemReq   <= 1'b1;
                            bus.MemWE    <= MemWrite;
                            bus.MemAddr  <= Address[31:2];
                            bus.MemBE    <= MemWrite ? st_fmt[35:32] : 4'b1111;
                            bus.MemWData <= MemWrite ? st_fmt[31:0] : 32'd0;
                        end
                    end
                end
            endcase
            // Last assignment wins, so a clear beats an LL completing in the same cycle.
            if (LLClear) llbit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a byte-array memory model with LL/SC tracking.
module tb_mem_access_unit;
    localparam int TO = 8;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        MemRead, MemWrite, Link, Cond, LLClear;
    logic [2:0]  MemFunc;
    logic [31:0] Address, RtData, ReadData;
    logic        Stall, Done, AddrErr, BusErr;

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .Clock(Clock), .nReset(nReset), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemFunc(MemFunc), .Link(Link), .Cond(Cond), .LLClear(LLClear),
        .Address(Address), .RtData(RtData), .ReadData(ReadData), .Stall(Stall),
        .Done(Done), .AddrErr(AddrErr), .BusErr(BusErr), .bus(bus)
    );

    always #5 Clock = ~Clock;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  memb [0:1023];
    bit          llbit_m;
    logic [29:0] lladdr_m;
    logic [31:0] last_rd, last_wd;
    logic [29:0] last_maddr;
    logic [3:0]  last_be;
    int          last_stalls;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int wbase(input logic [31:0] a);
        return int'({a[9:2], 2'b00});
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        int b;
        b = wbase(a);
        return {memb[b], memb[b+1], memb[b+2], memb[b+3]};
    endfunction

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        int b;
        b = wbase(a);
        for (int n = 0; n < 4; n++) memb[b+n] = v[31-8*n -: 8];
    endtask

    // Register byte n is bits 31-8n..24-8n; memory offset 0 is the most significant lane.
    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] rt);
        int b, k, o;
        logic [31:0] r;
        logic [15:0] h;
        b = wbase(a);
        k = int'(a[1:0]);
        o = b + k;
        r = rt;
        case (f)
            3'b000: r = 32'($signed(memb[o]));
            3'b100: r = {24'd0, memb[o]};
            3'b001: begin h = {memb[o], memb[o+1]}; r = 32'($signed(h)); end
            3'b101: r = {16'd0, memb[o], memb[o+1]};
            3'b010: for (int i = 0; i <= 3 - k; i++) r[31-8*i -: 8] = memb[b+k+i];
            3'b110: for (int j = 0; j <= k; j++) r[31-8*(3-k+j) -: 8] = memb[b+j];
            default: r = word_at(a);
        endcase
        return r;
    endfunction

    task automatic ref_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] rt,
                             output logic [3:0] be, output logic [31:0] wd);
        bit         en [4];
        logic [7:0] val [4];
        logic [7:0] rb [4];
        int         k;
        k = int'(a[1:0]);
        for (int n = 0; n < 4; n++) begin
            en[n] = 1'b0;
            val[n] = 8'd0;
            rb[n] = rt[31-8*n -: 8];
        end
        case (f)
            3'b000, 3'b100: begin en[k] = 1; val[k] = rb[3]; end
            3'b001, 3'b101: if (k < 3) begin
                en[k] = 1; val[k] = rb[2]; en[k+1] = 1; val[k+1] = rb[3];
            end
            3'b010: for (int i = 0; i <= 3 - k; i++) begin en[k+i] = 1; val[k+i] = rb[i]; end
            3'b110: for (int j = 0; j <= k; j++) begin en[j] = 1; val[j] = rb[3-k+j]; end
            default: for (int n = 0; n < 4; n++) begin en[n] = 1; val[n] = rb[n]; end
        endcase
        be = '0;
        wd = '0;
        for (int o = 0; o < 4; o++) begin
            be[3-o] = en[o];
            wd[31-8*o -: 8] = val[o];
        end
    endtask

    task automatic apply_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        int b;
        b = wbase(a);
        for (int o = 0; o < 4; o++) if (be[3-o]) memb[b+o] = wd[31-8*o -: 8];
    endtask

    // Called at a falling edge; returns at the falling edge on which Done was observed.
    task automatic do_op(input bit rd, input bit wr, input logic [2:0] func, input bit lnk,
                         input bit cnd, input logic [31:0] addr, input logic [31:0] rt,
                         input int delay);
        logic [2:0]  eff;
        logic [1:0]  k;
        bit          mis, sc, ll, sc_ok, use_bus, to_err, seen;
        logic [31:0] exp_rd, exp_wd, m;
        logic [3:0]  exp_be;
        int          cyc, reqs, stalls;
        sc      = wr && cnd;
        ll      = !wr && lnk;
        eff     = (sc || ll) ? 3'b011 : func;
        k       = addr[1:0];
        mis     = (eff == 3'b001 || eff == 3'b101) ? addr[0] :
                  (eff == 3'b011 || eff == 3'b111) ? (k != 2'b00) : 1'b0;
        sc_ok   = llbit_m && (lladdr_m == addr[31:2]);
        use_bus = !mis && !(sc && !sc_ok);
        to_err  = use_bus && (delay >= TO);
        exp_rd  = ref_load(eff, addr, rt);
        ref_store(eff, addr, rt, exp_be, exp_wd);
        m = {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}};

        MemRead = rd; MemWrite = wr; MemFunc = func; Link = lnk; Cond = cnd;
        Address = addr; RtData = rt;
        #1 chk("stall_req", 32'(Stall), 32'd1);
        stalls = 1; cyc = 0; reqs = 0; seen = 0;
        while (!seen && cyc < 60) begin
            @(negedge Clock);
            cyc++;
            if (Done) seen = 1;
            else stalls += int'(Stall);
            if (bus.MemReq) begin
                reqs++;
                if (reqs == 1) begin
                    last_be = bus.MemBE; last_wd = bus.MemWData; last_maddr = bus.MemAddr;
                    chk("bus_we", 32'(bus.MemWE), 32'(wr));
                    chk("bus_addr", 32'(bus.MemAddr), 32'(addr[31:2]));
                    if (wr) begin
                        chk("bus_be", 32'(bus.MemBE), 32'(exp_be));
                        chk("bus_wdata", bus.MemWData & m, exp_wd & m);
                    end
                end
                bus.MemAck   = (reqs - 1 == delay);
                bus.MemRData = (reqs - 1 == delay) ? word_at(addr) : $urandom;
            end else begin
                bus.MemAck = 1'b0;
            end
        end
        MemRead = 0; MemWrite = 0; Link = 0; Cond = 0;
        last_rd = ReadData;
        last_stalls = stalls;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", cyc, use_bus ? (to_err ? TO + 1 : delay + 2) : 1);
        chk("req_cycles", reqs, use_bus ? (to_err ? TO : delay + 1) : 0);
        chk("stall_cycles", stalls, cyc);
        chk("addr_err", 32'(AddrErr), 32'(mis));
        chk("bus_err", 32'(BusErr), 32'(to_err));
        if (use_bus && !to_err && !wr) chk("rdata", ReadData, exp_rd);
        if (sc && !mis && !to_err) chk("sc_status", ReadData, 32'(sc_ok));
        #1 chk("stall_release", 32'(Stall), 32'd0);
        if (use_bus && !to_err) begin
            if (wr) apply_store(addr, exp_be, exp_wd);
            if (ll) begin llbit_m = 1; lladdr_m = addr[31:2]; end
        end
        if (sc && !mis && !to_err) llbit_m = 0;
    endtask

    task automatic ll_clear();
        LLClear = 1'b1;
        @(negedge Clock);
        LLClear = 1'b0;
        llbit_m = 0;
    endtask

    logic [31:0] ra, rrt, b2b_rt, b2b_wd;
    logic [3:0]  b2b_be;
    logic [2:0]  sfun [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110};
    int          sel, dly;

    initial begin
        nReset = 0; MemRead = 0; MemWrite = 0; MemFunc = 0; Link = 0; Cond = 0; LLClear = 0;
        Address = 0; RtData = 0; bus.MemAck = 0; bus.MemRData = 0;
        llbit_m = 0; lladdr_m = 0;
        for (int i = 0; i < 1024; i++) memb[i] = 8'($urandom);
        repeat (2) @(negedge Clock);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_memreq", 32'(bus.MemReq), 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_errs", {30'd0, AddrErr, BusErr}, 32'd0);
        nReset = 1;
        @(negedge Clock);

        set_word(32'h1000, 32'h11A2_3344);
        do_op(1, 0, 3'b000, 0, 0, 32'h1001, 32'd0, 0);
        chk("lb_const", last_rd, 32'hFFFF_FFA2);
        chk("lb_stall2", last_stalls, 2);
        do_op(1, 0, 3'b100, 0, 0, 32'h1001, 32'd0, 0);
        chk("lbu_const", last_rd, 32'h0000_00A2);
        do_op(0, 1, 3'b001, 0, 0, 32'h2002, 32'h0000_BEEF, 1);
        chk("sh_be", 32'(last_be), 32'h3);
        chk("sh_wdata", last_wd, 32'hBEEF_BEEF);
        chk("sh_maddr", 32'(last_maddr), 32'h800);
        set_word(32'h0, 32'hAABB_CCDD);
        do_op(1, 0, 3'b010, 0, 0, 32'h1, 32'h1122_3344, 0);
        chk("lwl_const", last_rd, 32'hBBCC_DD44);
        do_op(1, 0, 3'b110, 0, 0, 32'h1, 32'h1122_3344, 2);
        chk("lwr_const", last_rd, 32'h1122_AABB);
        do_op(1, 0, 3'b011, 0, 0, 32'h6, 32'd0, 0);
        do_op(1, 0, 3'b011, 1, 0, 32'h40, 32'd0, 0);
        do_op(0, 1, 3'b011, 0, 1, 32'h40, 32'h5A5A_0001, 0);
        chk("sc1_ok", last_rd, 32'd1);
        do_op(0, 1, 3'b011, 0, 1, 32'h40, 32'h5A5A_0002, 0);
        chk("sc2_fail", last_rd, 32'd0);
        do_op(1, 0, 3'b011, 1, 0, 32'h40, 32'd0, 1);
        ll_clear();
        do_op(0, 1, 3'b011, 0, 1, 32'h40, 32'h5A5A_0003, 0);
        chk("sc_cleared", last_rd, 32'd0);
        do_op(1, 0, 3'b011, 0, 0, 32'h10, 32'd0, TO + 5);

        // Reset during BUSY: request must drop immediately and no completion appears.
        do_op(1, 0, 3'b011, 1, 0, 32'h80, 32'd0, 0);
        MemRead = 1; MemFunc = 3'b011; Address = 32'h10; bus.MemAck = 0;
        @(negedge Clock);
        chk("rp_req_on", 32'(bus.MemReq), 32'd1);
        @(negedge Clock);
        nReset = 0;
        #1 chk("rp_req_off", 32'(bus.MemReq), 32'd0);
        chk("rp_done_off", 32'(Done), 32'd0);
        MemRead = 0;
        llbit_m = 0;
        @(negedge Clock);
        nReset = 1;
        @(negedge Clock);
        chk("rp_no_done", 32'(Done), 32'd0);
        do_op(0, 1, 3'b011, 0, 1, 32'h80, 32'h1234_5678, 0);
        chk("rp_sc_fail", last_rd, 32'd0);

        // Back-to-back SW then LW with ack held high.
        b2b_rt = $urandom;
        ref_store(3'b011, 32'h100, b2b_rt, b2b_be, b2b_wd);
        bus.MemAck = 1; MemWrite = 1; MemFunc = 3'b011; Address = 32'h100; RtData = b2b_rt;
        for (int n = 1; n <= 4; n++) begin
            @(negedge Clock);
            chk("b2b_done", 32'(Done), 32'(n % 2 == 0));
            if (n == 2) begin
                apply_store(32'h100, b2b_be, b2b_wd);
                MemWrite = 0; MemRead = 1;
                bus.MemRData = word_at(32'h100);
            end
            if (n == 4) chk("b2b_rdata", ReadData, b2b_rt);
        end
        MemRead = 0; bus.MemAck = 0;
        @(negedge Clock);

        for (int i = 0; i < 200; i++) begin
            sel = $urandom_range(0, 9);
            ra  = 32'($urandom_range(0, 1023));
            rrt = $urandom;
            dly = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) dly = TO + 2;
            if (sel < 4)
                do_op(1, 0, 3'($urandom_range(0, 6)), 0, 0, ra, rrt, dly);
            else if (sel < 7)
                do_op(0, 1, sfun[$urandom_range(0, 4)], 0, 0, ra, rrt, dly);
            else if (sel < 9) begin
                ra = 32'h40 + 32'(4 * $urandom_range(0, 2));
                if ($urandom_range(0, 7) == 0) ra = ra + 2;
                if (sel == 7) do_op(1, 0, 3'b011, 1, 0, ra, rrt, dly);
                else          do_op(0, 1, 3'b011, 0, 1, ra, rrt, dly);
            end else
                ll_clear();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end
endmodule
